// File: rtl/bitscan_pkg.sv
// Shared definitions for the bitscan_iter set-bit iterator.
package bitscan_pkg;

    localparam int WIDTH = 16;
    localparam int IDXW  = 4;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [IDXW-1:0]  idx_t;
    typedef logic [IDXW:0]    cnt_t;

endpackage

// File: rtl/msb.sv
// Most-significant-bit isolator: keeps only the highest set bit of din.
module msb #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = '0;
        // Ascending scan: the last set bit seen is the highest one.
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (din[i]) begin
                dout    = '0;
                dout[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/onehot_enc.sv
// One-hot to binary index encoder; an all-zero input encodes to 0.
module onehot_enc #(
    parameter int WIDTH = 16,
    parameter int IDXW  = 4
) (
    input  logic [WIDTH-1:0] onehot,
    output logic [IDXW-1:0]  idx
);

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                idx = idx | IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/ones.sv
// Population counter: number of set bits in din.
module ones #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] din,
    output logic [CW-1:0]    count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            count = count + CW'(din[i]);
        end
    end

endmodule

// File: rtl/bitscan_iter.sv
// Set-bit iterator: accepts a word, emits each set-bit index highest first.
// Define BITSCAN_COUNT_EN to report the word's popcount on out_count.
module bitscan_iter #(
    parameter int WIDTH = 16,
    parameter int IDXW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             out_empty,
    output logic [IDXW:0]    out_count
);

    import bitscan_pkg::*;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] rest;
    idx_t            top_idx;
    cnt_t            cnt;
    logic            accept;
    logic            take;
    logic            is_last;

    msb #(.WIDTH(WIDTH)) u_msb (
        .din  (rem),
        .dout (top)
    );

    onehot_enc #(.WIDTH(WIDTH), .IDXW(IDXW)) u_enc (
        .onehot (top),
        .idx    (top_idx)
    );

    assign rest    = rem & ~top;
    assign is_last = (rest == '0);
    assign accept  = (state == IDLE) && in_valid;
    assign take    = (state == EMIT) && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)             state_nxt = EMIT;
            EMIT:    if (out_ready && is_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rem is cleared on the final take so IDLE always shows an empty word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem <= '0;
        end else if (accept) begin
            rem <= in_data;
        end else if (take) begin
            rem <= is_last ? '0 : rest;
        end
    end

`ifdef BITSCAN_COUNT_EN
    cnt_t pop;

    ones #(.WIDTH(WIDTH), .CW(IDXW + 1)) u_ones (
        .din   (in_data),
        .count (pop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= pop;
        end
    end
`else
    assign cnt = '0;
`endif

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_last  = 1'b0;
        out_empty = 1'b0;
        out_count = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_idx   = top_idx;
                out_last  = is_last;
                // rem can only be zero in EMIT when the accepted word was zero.
                out_empty = (rem == '0);
                out_count = cnt;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule
